// File: rtl/ps2_key_cmd_ctrl_if.sv
// Key-event input and command output handshake between the PS/2 receiver,
// the key/command controller and the game FSM. The slave modport is the controller's view.
interface ps2_key_cmd_ctrl_if;
   logic       key_valid;
   logic [9:0] key_code;
   logic       cmd_valid;
   logic [2:0] cmd;
   logic       cmd_ready;

   modport master (output key_valid, key_code, cmd_ready, input cmd_valid, cmd);
   modport slave  (input key_valid, key_code, cmd_ready, output cmd_valid, cmd);
endinterface

// File: rtl/ps2_key_cmd_ctrl.sv
// Decodes PS/2 move/restart keys, suppresses typematic repeat and queues one
// command per physical press in a small FIFO with a valid/ready output.
module ps2_key_cmd_ctrl #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   ps2_key_cmd_ctrl_if.slave       bus,
   input  logic                    enable,
   input  logic                    flush,
   input  logic                    clr_ovf,
   output logic [8:0]              held,
   output logic                    ovf,
   output logic [7:0]              drop_cnt
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [2:0]    r_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [AW:0]   r_count;
   logic [8:0]    r_held;
   logic          r_ovf;
   logic [7:0]    r_drop_cnt;

   logic          w_ext;
   logic          w_brk;
   logic [7:0]    w_sc;
   logic          w_hit;
   logic [3:0]    w_idx;
   logic [2:0]    w_cmd;
   logic          w_key_ev;
   logic          w_press;
   logic          w_push_req;
   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;

   assign w_ext = bus.key_code[9];
   assign w_brk = bus.key_code[8];
   assign w_sc  = bus.key_code[7:0];

   always_comb begin
      // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
      w_hit = 1'b1;
      w_idx = 4'd0;
      w_cmd = 3'd0;
      case ({w_ext, w_sc})
         9'h01D:  begin w_idx = 4'd0; w_cmd = 3'd0; end
         9'h01B:  begin w_idx = 4'd1; w_cmd = 3'd1; end
         9'h01C:  begin w_idx = 4'd2; w_cmd = 3'd2; end
         9'h023:  begin w_idx = 4'd3; w_cmd = 3'd3; end
         9'h175:  begin w_idx = 4'd4; w_cmd = 3'd0; end
         9'h172:  begin w_idx = 4'd5; w_cmd = 3'd1; end
         9'h16B:  begin w_idx = 4'd6; w_cmd = 3'd2; end
         9'h174:  begin w_idx = 4'd7; w_cmd = 3'd3; end
         9'h02D:  begin w_idx = 4'd8; w_cmd = 3'd4; end
         default: w_hit = 1'b0;
      endcase
   end

   // A make on an already-held key is typematic repeat and is ignored.
   assign w_key_ev   = bus.key_valid & w_hit;
   assign w_press    = w_key_ev & ~w_brk & ~r_held[w_idx];
   assign w_push_req = w_press & enable & ~flush;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_CNT);
   assign w_pop   = ~w_empty & bus.cmd_ready & ~flush;
   assign w_push  = w_push_req & (~w_full | w_pop);
   assign w_drop  = w_push_req & w_full & ~w_pop;

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (rst)
         r_held <= '0;
      else if (w_key_ev)
         r_held[w_idx] <= ~w_brk;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the storage is reset because cmd must read 0 out of reset; it is only a few flops here.
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= 3'd0;
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= w_cmd;
      end
   end

   // A drop in the same cycle as clr_ovf wins and restarts the count at one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf      <= 1'b0;
         r_drop_cnt <= 8'd0;
      end else if (w_drop) begin
         r_ovf      <= 1'b1;
         if (clr_ovf)
            r_drop_cnt <= 8'd1;
         else if (r_drop_cnt != 8'hFF)
            r_drop_cnt <= r_drop_cnt + 8'd1;
      end else if (clr_ovf) begin
         r_ovf      <= 1'b0;
         r_drop_cnt <= 8'd0;
      end
   end

   assign bus.cmd_valid = ~w_empty;
   assign bus.cmd       = r_mem[r_rd_ptr];
   assign held          = r_held;
   assign ovf           = r_ovf;
   assign drop_cnt      = r_drop_cnt;

endmodule

// File: doc/ps2_key_cmd_ctrl.md
Name: ps2_key_cmd_ctrl

Overview:
- Sits between the PS/2 scancode receiver and the 2048 game-logic FSM.
- Takes one-cycle scancode events {extended, break, code[7:0]} and decodes the move/restart keys.
- Suppresses keyboard typematic auto-repeat, so one physical press produces exactly one command.
- Queues commands in a small FIFO with a valid/ready handshake, so key events are never lost while the game FSM is busy shifting and merging tiles.

Parameters:
- DEPTH, 4, FIFO depth in entries; power of two, 2..16.
- AW, 2, FIFO pointer width; must equal log2(DEPTH).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- key_valid, input, 1, one-cycle pulse: key_code is valid this cycle.
- key_code, input, 10, {extended, break, scancode[7:0]}.
- enable, input, 1, when 0, new presses are not enqueued.
- flush, input, 1, synchronous clear of the FIFO contents.
- clr_ovf, input, 1, synchronous clear of ovf and drop_cnt.
- cmd_valid, output, 1, FIFO head is valid.
- cmd, output, 3, FIFO head command: 0 up, 1 down, 2 left, 3 right, 4 restart.
- cmd_ready, input, 1, consumer accepts the head when cmd_valid=1.
- held, output, 9, per-key pressed state (debug/LED).
- ovf, output, 1, sticky: at least one press was dropped because the FIFO was full.
- drop_cnt, output, 8, saturating count of dropped presses.

Behaviour:
- Decode is combinational on key_code. Key index / command mapping:
  - idx0: W 1D, ext=0, cmd up.
  - idx1: S 1B, ext=0, cmd down.
  - idx2: A 1C, ext=0, cmd left.
  - idx3: D 23, ext=0, cmd right.
  - idx4: E0 75, cmd up.
  - idx5: E0 72, cmd down.
  - idx6: E0 6B, cmd left.
  - idx7: E0 74, cmd right.
  - idx8: R 2D, ext=0, cmd restart.
- The extended bit must match exactly: ext=1 with code 1D does not map. Unmapped codes are ignored entirely and leave no state change.
- Per mapped key_valid event:
  - break=1: held[idx] <= 0. No enqueue.
  - break=0 and held[idx]=1: typematic repeat. Discarded; not counted as a drop.
  - break=0 and held[idx]=0: held[idx] <= 1, and the command is pushed if enable=1. If enable=0 the press is marked held but not queued, so it does not fire when enable later rises.
- FIFO:
  - Registered storage, DEPTH entries, read/write pointers plus a count of AW+1 bits.
  - cmd_valid = (count != 0); cmd = mem[rd_ptr].
  - Pop when cmd_valid & cmd_ready. Pointers wrap modulo DEPTH.
- Latency: a push at edge N makes cmd_valid=1 after edge N (visible in cycle N+1) when the FIFO was empty. No combinational path from key_valid to cmd_valid.
- Full: a push with count==DEPTH and no simultaneous pop is dropped. ovf <= 1; drop_cnt increments, saturating at 255; held[idx] is still set.
- Push and pop in the same cycle: both are performed and count is unchanged. This holds when full: the push is accepted and not dropped.
- Empty: cmd_ready is ignored; a pop never occurs.
- flush=1 has priority over push and pop:
  - count, rd_ptr, wr_ptr <= 0.
  - held is unaffected.
  - A push in the same cycle is discarded.
- clr_ovf=1: ovf <= 0 and drop_cnt <= 0. A drop in the same cycle wins: ovf=1, drop_cnt=1.
- cmd stays stable while cmd_valid=1 and cmd_ready=0.
- Reset (rst=1, asynchronous): cmd_valid=0, cmd=0, held=0, ovf=0, drop_cnt=0, pointers=0, count=0. Reset mid-operation discards all queued commands.
- key_valid is at most one pulse per scancode; back-to-back pulses on consecutive cycles must be handled.

Test Plan:
- Make-only W (key_code 0x01D, key_valid 1 cycle), cmd_ready=1 → cmd_valid high for exactly 1 cycle, starting the cycle after the pulse; cmd=0; held[0]=1.
- Typematic sequence: E0 6B make ×5 (0x26B), then break 0x36B, then make again → exactly 2 left commands (cmd=2) total; held[6]=0 after the break.
- cmd_ready=0, then 6 distinct presses (W, S, A, D, up, down, each make+break) with DEPTH=4 → 4 entries queued in order 0,1,2,3; ovf=1; drop_cnt=2. Then pulse clr_ovf → ovf=0, drop_cnt=0. Then drain → outputs 0,1,2,3 and cmd_valid falls.
- FIFO full with cmd_ready=1 and a press of R (0x02D) in the same cycle → head popped, restart (cmd=4) accepted at the tail, ovf stays 0, count stays 4.
- enable=0, press D (0x023) → nothing queued, held[3]=1. Raise enable → still no command. Break 0x123, then press D again → one cmd=3.
- Queue 3 commands, then assert flush together with a new press → cmd_valid=0 next cycle, held unchanged. Assert rst asynchronously mid-queue → all outputs return to their reset values immediately.
